// File: rtl/core_pkg.sv
// Shared core definitions: datapath width, reset vector, bubble encoding and
// the fetch-stage state encoding.
package core_pkg;

  localparam int          XLEN      = 32;
  localparam logic [31:0] RESET_PC  = 32'h0040_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef logic [1:0] fetch_state_t;

  localparam fetch_state_t S_FETCH = 2'd0;
  localparam fetch_state_t S_HOLD  = 2'd1;
  localparam fetch_state_t S_DROP  = 2'd2;

endpackage

// File: rtl/fetch_stage_ifid_reg.sv
// IF/ID pipeline register: flush beats load, load beats bubble, bubble beats hold.
module ifid_reg #(
  parameter int              XLEN      = core_pkg::XLEN,
  parameter logic [31:0]     NOP_INSTR = core_pkg::NOP_INSTR
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              load,
  input  logic              avail,
  input  logic [31:0]       data,
  input  logic [XLEN-1:0]   pc,
  output logic [XLEN-1:0]   ifid_pc,
  output logic [XLEN-1:0]   ifid_pc4,
  output logic [31:0]       ifid_instr,
  output logic              ifid_valid,
  output logic              fetch_stall
);

  logic [XLEN-1:0] pc_p1;
  logic [XLEN-1:0] pc4_p1;
  logic [31:0]     instr_p1;
  logic            vld_p1;
  logic            stall_p1;

  // IF -> ID boundary
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_p1    <= '0;
      pc4_p1   <= XLEN'(4);
      instr_p1 <= NOP_INSTR;
      vld_p1   <= 1'b0;
      stall_p1 <= 1'b0;
    end else begin
      stall_p1 <= 1'b0;
      if (clear) begin
        instr_p1 <= NOP_INSTR;
        vld_p1   <= 1'b0;
      end else if (load && avail) begin
        pc_p1    <= pc;
        pc4_p1   <= pc + XLEN'(4);
        instr_p1 <= data;
        vld_p1   <= 1'b1;
      end else if (load) begin
        instr_p1 <= NOP_INSTR;
        vld_p1   <= 1'b0;
        stall_p1 <= 1'b1;
      end
    end
  end

  assign ifid_pc     = pc_p1;
  assign ifid_pc4    = pc4_p1;
  assign ifid_instr  = instr_p1;
  assign ifid_valid  = vld_p1;
  assign fetch_stall = stall_p1;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, single-outstanding imem handshake with a
// one-entry hold buffer, in-flight discard on redirect, and the IF/ID register.
module fetch_stage #(
  parameter int          XLEN      = core_pkg::XLEN,
  parameter logic [31:0] RESET_PC  = core_pkg::RESET_PC,
  parameter logic [31:0] NOP_INSTR = core_pkg::NOP_INSTR
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_pcwrite,
  input  logic              in_ifidwrite,
  input  logic              in_ifid_clear,
  input  logic              in_redirect,
  input  logic [XLEN-1:0]   in_redirect_pc,
  output logic              imem_req,
  output logic [XLEN-1:0]   imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic [XLEN-1:0]   out_ifid_pc,
  output logic [XLEN-1:0]   out_ifid_pc4,
  output logic [31:0]       out_ifid_instr,
  output logic              out_ifid_valid,
  output logic              out_fetch_stall
);

  import core_pkg::*;

  fetch_state_t    state;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] drop_addr;
  logic [31:0]     hold_buf;

  logic            avail;
  logic [31:0]     data;
  logic            consumed;
  logic [XLEN-1:0] redirect_tgt;

  assign avail        = ((state == S_FETCH) && imem_ack) || (state == S_HOLD);
  assign data         = (state == S_HOLD) ? hold_buf : imem_rdata;
  assign consumed     = in_ifidwrite && in_pcwrite && avail;
  // Targets are word aligned; the low two bits are dropped here.
  assign redirect_tgt = in_redirect_pc & ~XLEN'(3);

  assign imem_req  = (state == S_FETCH) || (state == S_DROP);
  assign imem_addr = (state == S_DROP) ? drop_addr : pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc    <= RESET_PC;
      state <= S_FETCH;
    end else begin
      if (in_redirect) begin
        pc <= redirect_tgt;
      end else if (consumed) begin
        pc <= pc + XLEN'(4);
      end

      case (state)
        S_FETCH: begin
          if (in_redirect) begin
            if (!imem_ack) begin
              state <= S_DROP;
            end
          end else if (imem_ack && !consumed) begin
            state <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (in_redirect || consumed) begin
            state <= S_FETCH;
          end
        end
        S_DROP: begin
          if (imem_ack) begin
            state <= S_FETCH;
          end
        end
        default: state <= S_FETCH;
      endcase
    end
  end

  // The in-flight address and the held instruction are pure data; the state
  // register decides whether they are meaningful.
  always_ff @(posedge clk) begin
    if ((state == S_FETCH) && in_redirect && !imem_ack) begin
      drop_addr <= pc;
    end
    if ((state == S_FETCH) && !in_redirect && imem_ack && !consumed) begin
      hold_buf <= imem_rdata;
    end
  end

  ifid_reg #(
    .XLEN      (XLEN),
    .NOP_INSTR (NOP_INSTR)
  ) u_ifid_reg (
    .clk         (clk),
    .rst         (rst),
    .clear       (in_redirect || in_ifid_clear),
    .load        (in_ifidwrite),
    .avail       (avail),
    .data        (data),
    .pc          (pc),
    .ifid_pc     (out_ifid_pc),
    .ifid_pc4    (out_ifid_pc4),
    .ifid_instr  (out_ifid_instr),
    .ifid_valid  (out_ifid_valid),
    .fetch_stall (out_fetch_stall)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: hand-computed IF/ID and imem expectations.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_pcwrite = 1'b0;
  logic        in_ifidwrite = 1'b0;
  logic        in_ifid_clear = 1'b0;
  logic        in_redirect = 1'b0;
  logic [31:0] in_redirect_pc = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] out_ifid_pc;
  logic [31:0] out_ifid_pc4;
  logic [31:0] out_ifid_instr;
  logic        out_ifid_valid;
  logic        out_fetch_stall;

  int n_checks = 0;
  int n_errors = 0;

  fetch_stage dut (
    .clk             (clk),
    .rst             (rst),
    .in_pcwrite      (in_pcwrite),
    .in_ifidwrite    (in_ifidwrite),
    .in_ifid_clear   (in_ifid_clear),
    .in_redirect     (in_redirect),
    .in_redirect_pc  (in_redirect_pc),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ack        (imem_ack),
    .imem_rdata      (imem_rdata),
    .out_ifid_pc     (out_ifid_pc),
    .out_ifid_pc4    (out_ifid_pc4),
    .out_ifid_instr  (out_ifid_instr),
    .out_ifid_valid  (out_ifid_valid),
    .out_fetch_stall (out_fetch_stall)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic pcw, input logic ifw, input logic clr,
                       input logic redir, input logic [31:0] tgt,
                       input logic ack, input logic [31:0] rdata);
    in_pcwrite     = pcw;
    in_ifidwrite   = ifw;
    in_ifid_clear  = clr;
    in_redirect    = redir;
    in_redirect_pc = tgt;
    imem_ack       = ack;
    imem_rdata     = rdata;
  endtask

  task automatic check_ifid(input string tag, input logic [31:0] pc, input logic [31:0] instr,
                            input logic vld, input logic stall);
    check({tag, "_pc"}, out_ifid_pc, pc);
    check({tag, "_pc4"}, out_ifid_pc4, pc + 32'd4);
    check({tag, "_instr"}, out_ifid_instr, instr);
    check({tag, "_valid"}, {31'd0, out_ifid_valid}, {31'd0, vld});
    check({tag, "_stall"}, {31'd0, out_fetch_stall}, {31'd0, stall});
  endtask

  task automatic check_req(input string tag, input logic req, input logic [31:0] addr);
    check({tag, "_req"}, {31'd0, imem_req}, {31'd0, req});
    if (req) check({tag, "_addr"}, imem_addr, addr);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 rst = 1'b1;
    #1;
    check_ifid("rst", 32'h0, NOP, 1'b0, 1'b0);
    check_req("rst", 1'b1, 32'h0040_0000);
    @(posedge clk); @(posedge clk); #1 rst = 1'b0;

    // Zero-wait fetch
    drive(1, 1, 0, 0, 0, 1, 32'h0050_0093);
    cycle();
    check_ifid("zw0", 32'h0040_0000, 32'h0050_0093, 1'b1, 1'b0);
    check_req("zw0", 1'b1, 32'h0040_0004);
    cycle();
    check_ifid("zw1", 32'h0040_0004, 32'h0050_0093, 1'b1, 1'b0);
    check_req("zw1", 1'b1, 32'h0040_0008);

    // Stall: ack at 0x400008 not consumed, then two more stalled cycles
    drive(0, 0, 0, 0, 0, 1, 32'h00A0_0113);
    cycle();
    check_ifid("st0", 32'h0040_0004, 32'h0050_0093, 1'b1, 1'b0);
    check_req("st0", 1'b0, 32'h0);
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, 0, 0, 0, 1, 32'hBAD0_BAD0);
      cycle();
      check_ifid("st_hold", 32'h0040_0004, 32'h0050_0093, 1'b1, 1'b0);
      check_req("st_hold", 1'b0, 32'h0);
    end
    drive(1, 1, 0, 0, 0, 0, 32'h0);
    cycle();
    check_ifid("st_rel", 32'h0040_0008, 32'h00A0_0113, 1'b1, 1'b0);
    check_req("st_rel", 1'b1, 32'h0040_000C);

    // Redirect while request to 0x40000C is outstanding
    drive(1, 1, 0, 1, 32'h0040_0100, 0, 32'h0);
    cycle();
    check_ifid("rd0", 32'h0040_0008, NOP, 1'b0, 1'b0);
    check_req("rd0", 1'b1, 32'h0040_000C);
    drive(1, 1, 0, 0, 0, 0, 32'h0);
    cycle();
    check_ifid("rd1", 32'h0040_0008, NOP, 1'b0, 1'b1);
    check_req("rd1", 1'b1, 32'h0040_000C);
    drive(1, 1, 0, 0, 0, 1, 32'hDEAD_BEEF);
    cycle();
    check_ifid("rd2", 32'h0040_0008, NOP, 1'b0, 1'b1);
    check_req("rd2", 1'b1, 32'h0040_0100);

    // Redirect with ack in the same cycle, unaligned target
    drive(1, 1, 0, 1, 32'h0040_0203, 1, 32'h1111_1111);
    cycle();
    check_ifid("ra", 32'h0040_0008, NOP, 1'b0, 1'b0);
    check_req("ra", 1'b1, 32'h0040_0200);

    // Memory wait: four bubbles then a valid instruction
    for (int i = 0; i < 4; i++) begin
      drive(1, 1, 0, 0, 0, 0, 32'h0);
      cycle();
      check_ifid("mw_bub", 32'h0040_0008, NOP, 1'b0, 1'b1);
      check_req("mw_bub", 1'b1, 32'h0040_0200);
    end
    drive(1, 1, 0, 0, 0, 1, 32'h0030_0193);
    cycle();
    check_ifid("mw_ok", 32'h0040_0200, 32'h0030_0193, 1'b1, 1'b0);
    check_req("mw_ok", 1'b1, 32'h0040_0204);

    // Redirect together with ifid_clear, then PC wrap at the top of memory
    drive(1, 1, 1, 1, 32'hFFFF_FFFF, 1, 32'h2222_2222);
    cycle();
    check_ifid("wr0", 32'h0040_0200, NOP, 1'b0, 1'b0);
    check_req("wr0", 1'b1, 32'hFFFF_FFFC);
    drive(1, 1, 0, 0, 0, 1, 32'h0000_0113);
    cycle();
    check_ifid("wr1", 32'hFFFF_FFFC, 32'h0000_0113, 1'b1, 1'b0);
    check_req("wr1", 1'b1, 32'h0000_0000);

    // Enter DROP, then assert reset between clock edges
    drive(1, 1, 0, 1, 32'h0040_0500, 0, 32'h0);
    cycle();
    check_req("dr0", 1'b1, 32'h0000_0000);
    drive(1, 1, 0, 0, 0, 0, 32'h0);
    #2 rst = 1'b1;
    #1;
    check_ifid("arst", 32'h0, NOP, 1'b0, 1'b0);
    check_req("arst", 1'b1, 32'h0040_0000);
    @(posedge clk); #1 rst = 1'b0;
    drive(1, 1, 0, 0, 0, 1, 32'h0050_0093);
    cycle();
    check_ifid("post", 32'h0040_0000, 32'h0050_0093, 1'b1, 1'b0);
    check_req("post", 1'b1, 32'h0040_0004);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- PC register, instruction-memory request handshake and IF/ID pipeline register for the 5-stage RISC-V core.
- Sits directly upstream of the hazard unit and consumes its pcwrite, ifidwrite and ifid_clear outputs, plus the branch/JAL redirect from EX.
- Supports one outstanding fetch, a one-entry hold buffer for stalls, and discard of an in-flight fetch on redirect.

Parameters:
- XLEN, 32, datapath and address width.
- RESET_PC, 32'h0040_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013, bubble encoding (addi x0,x0,0).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_pcwrite  in  1  PC update enable from hazard unit.
- in_ifidwrite  in  1  IF/ID load enable from hazard unit.
- in_ifid_clear  in  1  flush IF/ID to bubble.
- in_redirect  in  1  taken branch or JAL/JALR resolved in EX.
- in_redirect_pc  in  XLEN  redirect target.
- imem_req  out  1  fetch request.
- imem_addr  out  XLEN  fetch address.
- imem_ack  in  1  fetch complete; imem_rdata valid this cycle.
- imem_rdata  in  32  fetched instruction.
- out_ifid_pc  out  XLEN  PC of the instruction in IF/ID.
- out_ifid_pc4  out  XLEN  out_ifid_pc + 4.
- out_ifid_instr  out  32  instruction in IF/ID.
- out_ifid_valid  out  1  IF/ID holds a real instruction.
- out_fetch_stall  out  1  IF/ID loaded a bubble because no instruction was available.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - pc = RESET_PC, state = FETCH.
  - out_ifid_instr = NOP_INSTR, out_ifid_valid = 0, out_ifid_pc = 0, out_ifid_pc4 = 4.
  - out_fetch_stall = 0. Reset mid-fetch abandons the request with no drain.
- imem_req = 1 only in states FETCH and DROP; imem_addr = pc in FETCH and the latched in-flight address in DROP.
- Handshake: while imem_req = 1, imem_addr is stable until imem_ack. imem_ack is ignored whenever imem_req = 0.
- "avail" is true when (state = FETCH and imem_ack) or state = HOLD. "data" is imem_rdata in FETCH and the hold buffer in HOLD.
- Target bits [1:0] are forced to 0 when pc is loaded from in_redirect_pc.
- IF/ID update priority, registered with zero-cycle latency from ack to the IF/ID load on the same edge:
  1. in_redirect or in_ifid_clear: valid = 0, instr = NOP_INSTR.
  2. else if in_ifidwrite and avail: load data, pc and pc+4; valid = 1.
  3. else if in_ifidwrite and not avail: load a bubble; out_fetch_stall = 1 for that cycle, otherwise 0.
  4. else: hold all IF/ID fields.
- PC update:
  - in_redirect loads the target and overrides in_pcwrite.
  - Otherwise pc += 4 (mod 2^XLEN, wrapping) when in_pcwrite and in_ifidwrite and avail.
  - Otherwise pc holds.
- States:
  - FETCH:
    - redirect with no ack: latch the old address, then DROP.
    - redirect with ack: discard the data, stay in FETCH at the new pc.
    - ack with the instruction consumed: stay in FETCH at pc+4.
    - ack with the instruction not consumed (in_ifidwrite = 0 or in_pcwrite = 0): capture imem_rdata into the hold buffer, then HOLD.
  - HOLD:
    - redirect: discard the buffer, then FETCH.
    - instruction consumed: go to FETCH.
    - else: stay in HOLD.
  - DROP:
    - wait for imem_ack, discard the data, then FETCH.
    - a further redirect in DROP updates pc only.
- Simultaneous redirect and ifid_clear: identical result to redirect alone.
- Simultaneous in_ifidwrite = 0 and redirect: redirect wins and IF/ID is flushed.

Decomposition:
- Shared package core_pkg holds XLEN, NOP_INSTR, RESET_PC, and the fetch-state enum (FETCH, HOLD, DROP).
- One natural sub-module, ifid_reg: the IF/ID register with load/clear/hold priority. The FSM and PC logic stay in fetch_stage.

Test Plan:
- Zero-wait fetch: after reset, ack every cycle with rdata = 0x00500093 → IF/ID pc sequence 0x400000, 0x400004, …, valid = 1, imem_addr advances by 4 each cycle.
- Stall: ack at pc 0x400008, then in_pcwrite = 0 and in_ifidwrite = 0 for 3 cycles → state HOLD, imem_req = 0, IF/ID unchanged. On release, IF/ID pc = 0x400008 with the buffered instruction.
- Redirect in flight: req outstanding at 0x40000C with no ack, in_redirect with target 0x400100 → imem_addr stays 0x40000C until ack, data discarded, next request to 0x400100, IF/ID valid = 0 in between.
- Redirect with ack in the same cycle: target 0x400203 → pc = 0x400200, IF/ID = NOP with valid = 0.
- Memory wait: ack delayed 4 cycles with in_ifidwrite = 1 → 4 bubbles with out_fetch_stall = 1, then a valid instruction.
- Async reset asserted in DROP, between clock edges → outputs at reset values immediately; the first request after release is to 0x400000.
